// File: rtl/alu_req_arbiter.sv
// Purpose : shares one 4-bit signed ALU (add/sub/mul) between two requesters with
//           round-robin arbitration and a single operation in flight.
// Latency : resp_valid rises ALU_LAT+1 edges after the acceptance edge (1 edge for
//           an illegal op); back-to-back spacing is ALU_LAT+3 cycles.
// Backpressure: a pending response is held until resp_ready; no request is accepted
//           while busy (r0_ready/r1_ready stay low outside IDLE).
//
// Ports:
//   clk, ar                        clock, asynchronous active-high reset
//   r0_valid/r0_ready/r0_op/a/b    requester 0 (op 00 add, 01 sub, 10 mul, 11 illegal)
//   r1_valid/r1_ready/r1_op/a/b    requester 1
//   alu_select/alu_a/alu_b         registered operands driven to the shared ALU
//   alu_sign/alu_mag               ALU result, valid ALU_LAT edges after operands load
//   resp_valid/resp_ready          response handshake
//   resp_id/sign/mag/err           response payload
//   busy                           high whenever the FSM is not in IDLE
module alu_req_arbiter #(
    parameter int ALU_LAT = 1   // legal range 1..7
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       r0_valid,
    output logic       r0_ready,
    input  logic [1:0] r0_op,
    input  logic [3:0] r0_a,
    input  logic [3:0] r0_b,
    input  logic       r1_valid,
    output logic       r1_ready,
    input  logic [1:0] r1_op,
    input  logic [3:0] r1_a,
    input  logic [3:0] r1_b,
    output logic [1:0] alu_select,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic       alu_sign,
    input  logic [7:0] alu_mag,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic       resp_sign,
    output logic [7:0] resp_mag,
    output logic       resp_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    state_t     state;
    logic       last_id;    // requester granted most recently
    logic       req_id;     // owner of the operation in flight
    logic [2:0] cnt;        // remaining ALU latency edges

    logic       grant_any;
    logic       grant_id;
    logic [1:0] sel_op;
    logic [3:0] sel_a;
    logic [3:0] sel_b;

    // When both request, the one not granted last time wins; otherwise the sole
    // valid requester wins.
    always_comb begin
        grant_any = r0_valid | r1_valid;
        grant_id  = (r0_valid & r1_valid) ? ~last_id : r1_valid;
        sel_op    = grant_id ? r1_op : r0_op;
        sel_a     = grant_id ? r1_a  : r0_a;
        sel_b     = grant_id ? r1_b  : r0_b;
    end

    // Ready is combinational and gated by reset so every output reads 0 while
    // ar is asserted, even with requests pending.
    assign r0_ready = (state == S_IDLE) & ~ar & r0_valid & ~grant_id;
    assign r1_ready = (state == S_IDLE) & ~ar & r1_valid &  grant_id;
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge ar) begin
        if (ar) begin
            state      <= S_IDLE;
            last_id    <= 1'b1;     // makes r0 win the first contested grant
            req_id     <= 1'b0;
            cnt        <= 3'd0;
            alu_select <= 2'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_sign  <= 1'b0;
            resp_mag   <= 8'd0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        last_id <= grant_id;
                        req_id  <= grant_id;
                        if (sel_op == OP_ILLEGAL) begin
                            // ALU is bypassed: its operand registers keep their
                            // previous contents and the error response is immediate.
                            resp_valid <= 1'b1;
                            resp_id    <= grant_id;
                            resp_err   <= 1'b1;
                            resp_sign  <= 1'b0;
                            resp_mag   <= 8'd0;
                            state      <= S_RESP;
                        end else begin
                            alu_select <= sel_op;
                            alu_a      <= sel_a;
                            alu_b      <= sel_b;
                            cnt        <= 3'(ALU_LAT);
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= cnt - 3'd1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == 3'd0) begin
                        resp_valid <= 1'b1;
                        resp_id    <= req_id;
                        resp_err   <= 1'b0;
                        resp_sign  <= alu_sign;
                        resp_mag   <= alu_mag;
                        state      <= S_RESP;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: two instances (ALU_LAT=1 and ALU_LAT=3) share the same
// request stimulus, each with its own ALU model, reference model and scoreboard.
// Latency: not applicable. Backpressure: resp_ready is driven by the stimulus.
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       ar;
    logic       r0_valid, r1_valid, resp_ready;
    logic [1:0] r0_op, r1_op;
    logic [3:0] r0_a, r0_b, r1_a, r1_b;

    logic       r0_ready   [2];
    logic       r1_ready   [2];
    logic [1:0] alu_select [2];
    logic [3:0] alu_a      [2];
    logic [3:0] alu_b      [2];
    logic       alu_sign   [2];
    logic [7:0] alu_mag    [2];
    logic       resp_valid [2];
    logic       resp_id    [2];
    logic       resp_sign  [2];
    logic [7:0] resp_mag   [2];
    logic       resp_err   [2];
    logic       busy       [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_req_arbiter #(.ALU_LAT(1)) dut_l1 (
        .clk(clk), .ar(ar),
        .r0_valid(r0_valid), .r0_ready(r0_ready[0]), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready[0]), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .alu_select(alu_select[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_sign(alu_sign[0]), .alu_mag(alu_mag[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_id(resp_id[0]),
        .resp_sign(resp_sign[0]), .resp_mag(resp_mag[0]), .resp_err(resp_err[0]),
        .busy(busy[0])
    );

    alu_req_arbiter #(.ALU_LAT(3)) dut_l3 (
        .clk(clk), .ar(ar),
        .r0_valid(r0_valid), .r0_ready(r0_ready[1]), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready[1]), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .alu_select(alu_select[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_sign(alu_sign[1]), .alu_mag(alu_mag[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_id(resp_id[1]),
        .resp_sign(resp_sign[1]), .resp_mag(resp_mag[1]), .resp_err(resp_err[1]),
        .busy(busy[1])
    );

    // Signed 4-bit arithmetic returned as {sign, magnitude}.
    function automatic logic [8:0] arith(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        int r;
        int sa;
        int sb_;
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
        case (op)
            2'd0:    r = sa + sb_;
            2'd1:    r = sa - sb_;
            2'd2:    r = sa * sb_;
            default: r = 0;
        endcase
        return (r < 0) ? {1'b1, 8'(-r)} : {1'b0, 8'(r)};
    endfunction

    // ALU models: result appears ALU_LAT edges after the operands are presented.
    logic [8:0] pipe1      = '0;
    logic [8:0] pipe3 [3]  = '{default: '0};
    always @(posedge clk) begin
        pipe1    <= arith(alu_select[0], alu_a[0], alu_b[0]);
        pipe3[0] <= arith(alu_select[1], alu_a[1], alu_b[1]);
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    always_comb begin
        alu_sign[0] = pipe1[8];
        alu_mag[0]  = pipe1[7:0];
        alu_sign[1] = pipe3[2][8];
        alu_mag[1]  = pipe3[2][7:0];
    end

    typedef struct {
        bit         id;
        bit         err;
        bit         sign;
        logic [7:0] mag;
    } exp_t;

    exp_t       sb [2][$];
    bit         m_busy [2];
    bit         m_last [2];
    int         m_vis  [2];
    logic [1:0] e_sel  [2];
    logic [3:0] e_a    [2];
    logic [3:0] e_b    [2];

    task automatic chk(input int k, input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0d, expected %0d (cycle %0d)", k, name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_last[k] = 1'b1;
            m_vis[k]  = 0;
            e_sel[k]  = 2'd0;
            e_a[k]    = 4'd0;
            e_b[k]    = 4'd0;
            sb[k].delete();
        end
    endtask

    // Reference model, evaluated mid-cycle with inputs stable: predicts readiness,
    // busy, response visibility and the ALU operand registers, and on acceptance
    // pushes the expected response.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int   lat;
            bit   vis;
            bit   take0;
            bit   take1;
            bit   id;
            logic [1:0] op;
            logic [3:0] a;
            logic [3:0] b;
            logic [8:0] res;
            exp_t e;
            lat   = (k == 0) ? 1 : 3;
            vis   = m_busy[k] && (cyc >= m_vis[k]);
            take0 = !m_busy[k] && r0_valid && (!r1_valid || m_last[k]);
            take1 = !m_busy[k] && r1_valid && (!r0_valid || !m_last[k]);
            chk(k, "r0_ready",   int'(r0_ready[k]),   int'(take0));
            chk(k, "r1_ready",   int'(r1_ready[k]),   int'(take1));
            chk(k, "busy",       int'(busy[k]),       int'(m_busy[k]));
            chk(k, "resp_valid", int'(resp_valid[k]), int'(vis));
            chk(k, "alu_select", int'(alu_select[k]), int'(e_sel[k]));
            chk(k, "alu_a",      int'(alu_a[k]),      int'(e_a[k]));
            chk(k, "alu_b",      int'(alu_b[k]),      int'(e_b[k]));
            if (take0 || take1) begin
                id  = take1;
                op  = id ? r1_op : r0_op;
                a   = id ? r1_a  : r0_a;
                b   = id ? r1_b  : r0_b;
                e.id  = id;
                e.err = (op == 2'b11);
                res   = arith(op, a, b);
                e.sign = e.err ? 1'b0 : res[8];
                e.mag  = e.err ? 8'd0 : res[7:0];
                sb[k].push_back(e);
                m_busy[k] = 1'b1;
                m_last[k] = id;
                m_vis[k]  = cyc + 1 + (e.err ? 0 : lat + 1);
                if (!e.err) begin
                    e_sel[k] = op;
                    e_a[k]   = a;
                    e_b[k]   = b;
                end
            end else if (vis && resp_ready) begin
                m_busy[k] = 1'b0;
            end
        end
    endtask

    // Monitor: compares every presented response against the scoreboard head and
    // retires it on the handshake.
    always @(negedge clk) begin
        if (!ar) begin
            for (int k = 0; k < 2; k++) begin
                if (resp_valid[k]) begin
                    if (sb[k].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL dut%0d unexpected_resp: got resp_valid=1, required no response pending (cycle %0d)", k, cyc);
                    end else begin
                        chk(k, "resp_id",   int'(resp_id[k]),   int'(sb[k][0].id));
                        chk(k, "resp_err",  int'(resp_err[k]),  int'(sb[k][0].err));
                        chk(k, "resp_sign", int'(resp_sign[k]), int'(sb[k][0].sign));
                        chk(k, "resp_mag",  int'(resp_mag[k]),  int'(sb[k][0].mag));
                        if (resp_ready) void'(sb[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic set_req(input bit v0, input logic [1:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                           input bit v1, input logic [1:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                           input bit rr);
        r0_valid = v0; r0_op = o0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = o1; r1_a = a1; r1_b = b1;
        resp_ready = rr;
    endtask

    // Called just after a rising edge: check at the falling edge, return after the next rise.
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_req(0, 2'd0, 4'd0, 4'd0, 0, 2'd0, 4'd0, 4'd0, 1);
        repeat (n) tick();
    endtask

    task automatic chk_zero_outputs();
        for (int k = 0; k < 2; k++) begin
            chk(k, "rst_r0_ready",   int'(r0_ready[k]),   0);
            chk(k, "rst_r1_ready",   int'(r1_ready[k]),   0);
            chk(k, "rst_alu_select", int'(alu_select[k]), 0);
            chk(k, "rst_alu_a",      int'(alu_a[k]),      0);
            chk(k, "rst_alu_b",      int'(alu_b[k]),      0);
            chk(k, "rst_resp_valid", int'(resp_valid[k]), 0);
            chk(k, "rst_resp_id",    int'(resp_id[k]),    0);
            chk(k, "rst_resp_sign",  int'(resp_sign[k]),  0);
            chk(k, "rst_resp_mag",   int'(resp_mag[k]),   0);
            chk(k, "rst_resp_err",   int'(resp_err[k]),   0);
            chk(k, "rst_busy",       int'(busy[k]),       0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        ar = 1'b1;
        // Requests pending during reset must not produce ready.
        set_req(1, 2'd0, 4'd1, 4'd1, 1, 2'd0, 4'd1, 4'd1, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs();
        ar = 1'b0;

        // r0 add 3 + -5 = -2
        set_req(1, 2'd0, 4'd3, 4'hB, 0, 2'd0, 4'd0, 4'd0, 1);
        tick();
        idle(6);

        // Contention: grants alternate; 7*-8 = -56 and -8-7 = -15
        set_req(1, 2'd2, 4'd7, 4'h8, 1, 2'd1, 4'h8, 4'd7, 1);
        repeat (24) tick();
        idle(6);

        // Illegal op from r1: immediate error response, ALU operands untouched
        set_req(0, 2'd0, 4'd0, 4'd0, 1, 2'd3, 4'd5, 4'd6, 1);
        repeat (3) tick();
        idle(6);

        // Response backpressure for a long stretch, then release
        set_req(1, 2'd0, 4'd1, 4'd1, 1, 2'd1, 4'd2, 4'd4, 0);
        repeat (12) tick();
        resp_ready = 1'b1;
        repeat (4) tick();
        idle(6);

        // Reset while both instances are in WAIT
        set_req(1, 2'd0, 4'd2, 4'd3, 0, 2'd0, 4'd0, 4'd0, 1);
        tick();
        set_req(1, 2'd1, 4'd4, 4'd4, 1, 2'd1, 4'd4, 4'd4, 1);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        ar = 1'b1;
        #1;
        chk_zero_outputs();
        model_reset();
        @(posedge clk);
        #1;
        ar = 1'b0;
        // Both valid after reset: r0 must win
        tick();
        idle(8);

        // -8 * -8 = 64 on both latencies
        set_req(1, 2'd2, 4'h8, 4'h8, 0, 2'd0, 4'd0, 4'd0, 1);
        tick();
        idle(8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_req($urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                    $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom),
                    $urandom_range(0, 9) < 7);
            tick();
        end

        idle(12);
        for (int k = 0; k < 2; k++) chk(k, "drained", sb[k].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
